nibble_add_seq: RTL

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: multi-cycle W-bit adder (W = 4*NIBBLES). A single 4-bit
// ripple-carry adder is time-shared across the operand nibbles, least
// significant nibble first, with the nibble carry held in a register.
// Flow: IDLE --start--> ADD (NIBBLES cycles) --> DONE (one cycle) --> IDLE.
// sum, cout and ovf are registered and hold until the next accepted start.

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W      = 4 * NIBBLES;
    localparam int IDX_LOG = $clog2(NIBBLES + 1);
    localparam int IDXW   = (IDX_LOG < 1) ? 1 : IDX_LOG;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-adder cell: returns {carry, sum}; carry is the majority of the inputs.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
        return {co, s};
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              carry_r;
    logic [IDXW-1:0]   idx_r;
    logic [W-1:0]      sum_r;
    logic              cout_r;
    logic              ovf_r;
    logic              busy_r;
    logic              done_r;

    logic [3:0]        a_nib_s;
    logic [3:0]        b_nib_s;
    logic [4:0]        c_s;
    logic [3:0]        add_sum_s;
    logic [W-1:0]      sum_upd_s;
    logic              last_s;

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

    assign last_s = (idx_r == IDXW'(NIBBLES - 1));

    // Select the operand nibbles addressed by idx (AND-OR mux, no out-of-range index).
    always_comb begin
        a_nib_s = 4'd0;
        b_nib_s = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            a_nib_s = a_nib_s | (a_r[4*i +: 4] & {4{idx_r == IDXW'(i)}});
            b_nib_s = b_nib_s | (b_r[4*i +: 4] & {4{idx_r == IDXW'(i)}});
        end
    end

    // The single shared 4-bit ripple-carry adder built from four full-adder cells.
    always_comb begin
        c_s       = 5'd0;
        add_sum_s = 4'd0;
        c_s[0]    = carry_r;
        for (int k = 0; k < 4; k++) begin
            {c_s[k+1], add_sum_s[k]} = full_add(a_nib_s[k], b_nib_s[k], c_s[k]);
        end
    end

    // Merge the adder result into the addressed nibble of sum; other nibbles keep their value.
    always_comb begin
        sum_upd_s = sum_r;
        for (int i = 0; i < NIBBLES; i++) begin
            sum_upd_s[4*i +: 4] = (idx_r == IDXW'(i)) ? add_sum_s : sum_r[4*i +: 4];
        end
    end

    // Next-state logic for the IDLE/ADD/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus busy/done, registered from the next state so they track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ADD);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Datapath: operand capture on start, one nibble per ADD cycle, final carry/overflow on the last nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                    end else begin
                        a_r     <= a_r;
                        b_r     <= b_r;
                    end
                end
                ADD: begin
                    sum_r   <= sum_upd_s;
                    carry_r <= c_s[4];
                    idx_r   <= idx_r + IDXW'(1);
                    if (last_s) begin
                        cout_r <= c_s[4];
                        ovf_r  <= c_s[3] ^ c_s[4];
                    end else begin
                        cout_r <= cout_r;
                        ovf_r  <= ovf_r;
                    end
                end
                DONE: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

endmodule
